issue_scoreboard: RTL and testbench

Parametrised issue-stage hazard unit for the pipelined MIPS datapath; sits between the decode controller and the ID/EX pipeline register. Tracks, per architectural register, how many cycles remain until an in-flight result can be forwarded. Raises stall on read-after-write hazards, holds issue in a configurable branch shadow and honours flush. Generalises the single-cycle decoder with variable result latencies and a saturating stall counter.

---
 rtl/issue_scoreboard_if.sv | 36 +++
 rtl/issue_scoreboard.sv | 89 ++++++++
 tb/tb_issue_scoreboard.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/issue_scoreboard_if.sv
// Issue-stage bundle between the decode controller and the hazard unit.
// The decoder is the master; the scoreboard answers with Stall/IssueAck.
interface issue_scoreboard_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  // Handshake: IssueValid is the offer and ~Stall is the ready. An instruction
  // transfers in the cycle IssueAck (= IssueValid & ~Stall & ~Flush) is high;
  // the decoder must hold the instruction steady until that cycle.
  logic              IssueValid;
  logic [REG_AW-1:0] Rs;
  logic [REG_AW-1:0] Rt;
  logic              RsUsed;
  logic              RtUsed;
  logic [REG_AW-1:0] Dst;
  logic              DstWe;
  logic [1:0]        LatClass;
  logic              IsBranch;
  logic              BranchResolve;
  logic              Flush;
  logic              Stall;
  logic              IssueAck;
  logic [CNT_W-1:0]  StallCount;

  modport master (
    output IssueValid, Rs, Rt, RsUsed, RtUsed, Dst, DstWe, LatClass,
           IsBranch, BranchResolve, Flush,
    input  Stall, IssueAck, StallCount
  );

  modport slave (
    input  IssueValid, Rs, Rt, RsUsed, RtUsed, Dst, DstWe, LatClass,
           IsBranch, BranchResolve, Flush,
    output Stall, IssueAck, StallCount
  );
endinterface

// File: rtl/issue_scoreboard.sv
// Issue-stage hazard unit: per-register result countdowns, branch shadow and
// a saturating stall counter.
module issue_scoreboard #(
  parameter int REG_AW    = 5,
  parameter int LAT_W     = 3,
  parameter int LAT_LOAD  = 1,
  parameter int LAT_MUL   = 2,
  parameter int BR_SHADOW = 2,
  parameter int CNT_W     = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  issue_scoreboard_if.slave io
);
  localparam int NREG = 1 << REG_AW;

  logic [LAT_W-1:0] busy      [NREG];
  logic [LAT_W-1:0] busy_next [NREG];
  logic [LAT_W-1:0] shadow;
  logic [LAT_W-1:0] shadow_next;
  logic [CNT_W-1:0] stall_count;
  logic [LAT_W-1:0] lat;
  logic             rs_busy;
  logic             rt_busy;
  logic             hazard;
  logic             stall;
  logic             ack;
  logic             wr_en;

  always_comb begin
    lat = '0;
    case (io.LatClass)
      2'd1:    lat = LAT_W'(LAT_LOAD);
      2'd2:    lat = LAT_W'(LAT_MUL);
      default: lat = '0;
    endcase
  end

  assign rs_busy = io.RsUsed && (io.Rs != '0) && (busy[io.Rs] != '0);
  assign rt_busy = io.RtUsed && (io.Rt != '0) && (busy[io.Rt] != '0);
  assign hazard  = rs_busy || rt_busy;
  assign stall   = io.IssueValid && (hazard || (shadow != '0));
  assign ack     = io.IssueValid && !stall && !io.Flush;
  assign wr_en   = ack && io.DstWe && (io.Dst != '0);

  // A new write keeps the larger of its latency and the decayed old count so
  // a quick result never frees a register a slower one still owns.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      busy_next[r] = (busy[r] != '0) ? busy[r] - LAT_W'(1) : '0;
      if (r == 0) begin
        busy_next[r] = '0;
      end else if (wr_en && (io.Dst == REG_AW'(r)) && (lat > busy_next[r])) begin
        busy_next[r] = lat;
      end
    end
  end

  always_comb begin
    shadow_next = (shadow != '0) ? shadow - LAT_W'(1) : '0;
    if (ack && io.IsBranch) begin
      shadow_next = LAT_W'(BR_SHADOW);
    end else if (io.Flush || io.BranchResolve) begin
      shadow_next = '0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int r = 0; r < NREG; r++) begin
        busy[r] <= '0;
      end
      shadow      <= '0;
      stall_count <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        busy[r] <= busy_next[r];
      end
      shadow <= shadow_next;
      if (io.IssueValid && stall && !io.Flush && (stall_count != '1)) begin
        stall_count <= stall_count + CNT_W'(1);
      end
    end
  end

  assign io.Stall      = stall;
  assign io.IssueAck   = ack;
  assign io.StallCount = stall_count;
endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: directed test-plan scenarios with literal
// expectations plus randomized traffic against a ready-cycle reference model.
module tb_issue_scoreboard;
  localparam int REG_AW    = 5;
  localparam int CNT_W     = 16;
  localparam int CNT_W_SAT = 3;
  localparam int LAT_LOAD  = 1;
  localparam int LAT_MUL   = 2;
  localparam int BR_SHADOW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  issue_scoreboard_if #(.REG_AW(REG_AW), .CNT_W(CNT_W))     bus ();
  issue_scoreboard_if #(.REG_AW(REG_AW), .CNT_W(CNT_W_SAT)) bus_s ();

  assign bus_s.IssueValid    = bus.IssueValid;
  assign bus_s.Rs            = bus.Rs;
  assign bus_s.Rt            = bus.Rt;
  assign bus_s.RsUsed        = bus.RsUsed;
  assign bus_s.RtUsed        = bus.RtUsed;
  assign bus_s.Dst           = bus.Dst;
  assign bus_s.DstWe         = bus.DstWe;
  assign bus_s.LatClass      = bus.LatClass;
  assign bus_s.IsBranch      = bus.IsBranch;
  assign bus_s.BranchResolve = bus.BranchResolve;
  assign bus_s.Flush         = bus.Flush;

  issue_scoreboard #(.REG_AW(REG_AW), .LAT_W(3), .LAT_LOAD(LAT_LOAD), .LAT_MUL(LAT_MUL),
                     .BR_SHADOW(BR_SHADOW), .CNT_W(CNT_W)) dut (
    .Clk(clk), .Reset(rst), .io(bus.slave)
  );

  issue_scoreboard #(.REG_AW(REG_AW), .LAT_W(3), .LAT_LOAD(LAT_LOAD), .LAT_MUL(LAT_MUL),
                     .BR_SHADOW(BR_SHADOW), .CNT_W(CNT_W_SAT)) dut_s (
    .Clk(clk), .Reset(rst), .io(bus_s.slave)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each register records the absolute cycle from which its value can be
  // forwarded; the branch shadow records the first cycle issue is open again.
  int unsigned cyc = 0;
  int unsigned ready_at [32];
  int unsigned shadow_end = 0;
  int unsigned stall_total = 0;

  function automatic bit reg_pending(input logic [4:0] r);
    return (r != 0) && (ready_at[r] > cyc);
  endfunction

  function automatic int unsigned lat_of(input logic [1:0] lc);
    if (lc == 2'd1) return LAT_LOAD;
    if (lc == 2'd2) return LAT_MUL;
    return 0;
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    bit hz, exp_stall, exp_ack;
    int unsigned t;
    if (rst) begin
      for (int r = 0; r < 32; r++) ready_at[r] = 0;
      shadow_end  = 0;
      stall_total = 0;
    end
    hz = (bus.RsUsed && reg_pending(bus.Rs)) || (bus.RtUsed && reg_pending(bus.Rt));
    exp_stall = bus.IssueValid && (hz || (shadow_end > cyc));
    exp_ack   = bus.IssueValid && !exp_stall && !bus.Flush;
    check("stall", 32'(bus.Stall), 32'(exp_stall));
    check("issue_ack", 32'(bus.IssueAck), 32'(exp_ack));
    check("stall_count", 32'(bus.StallCount), (stall_total > 65535) ? 65535 : stall_total);
    check("stall_count_sat", 32'(bus_s.StallCount), (stall_total > 7) ? 7 : stall_total);
    if (!rst) begin
      if (exp_ack && bus.DstWe && bus.Dst != 0) begin
        t = cyc + 1 + lat_of(bus.LatClass);
        if (t > ready_at[bus.Dst]) ready_at[bus.Dst] = t;
      end
      if (exp_ack && bus.IsBranch) shadow_end = cyc + 1 + BR_SHADOW;
      else if (bus.Flush || bus.BranchResolve) shadow_end = cyc + 1;
      if (bus.IssueValid && exp_stall && !bus.Flush) stall_total++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    bus.IssueValid = 0; bus.Rs = 0; bus.Rt = 0; bus.RsUsed = 0; bus.RtUsed = 0;
    bus.Dst = 0; bus.DstWe = 0; bus.LatClass = 0; bus.IsBranch = 0;
    bus.BranchResolve = 0; bus.Flush = 0;
  endtask

  // dst/rs/rt of -1 mean "not written / not a source".
  task automatic instr(input int dst, input int lc, input int rs, input int rt, input bit br);
    idle();
    bus.IssueValid = 1;
    bus.DstWe  = (dst >= 0);
    bus.Dst    = (dst >= 0) ? 5'(dst) : 5'd0;
    bus.LatClass = 2'(lc);
    bus.RsUsed = (rs >= 0);
    bus.Rs     = (rs >= 0) ? 5'(rs) : 5'd0;
    bus.RtUsed = (rt >= 0);
    bus.Rt     = (rt >= 0) ? 5'(rt) : 5'd0;
    bus.IsBranch = br;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic at_neg();
    @(negedge clk); #1;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #3 rst = 1;
    @(posedge clk); #3 rst = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle();
    rst = 1;
    at_neg();
    check("reset_count", 32'(bus.StallCount), 0);
    check("reset_stall", 32'(bus.Stall), 0);
    pulse_reset();

    // load-use: one bubble
    step(); instr(8, 1, -1, -1, 0); at_neg(); check("lu_lw_ack", 32'(bus.IssueAck), 1);
    step(); instr(9, 0, 8, 8, 0);   at_neg(); check("lu_stall", 32'(bus.Stall), 1);
    check("lu_no_ack", 32'(bus.IssueAck), 0);
    step(); at_neg(); check("lu_add_ack", 32'(bus.IssueAck), 1);
    step(); idle(); at_neg(); check("lu_count", 32'(bus.StallCount), 1);

    // mul chain: two bubbles, none for unused source or $0
    pulse_reset();
    step(); instr(3, 2, -1, -1, 0);
    step(); instr(4, 0, 3, -1, 0); at_neg(); check("mul_stall1", 32'(bus.Stall), 1);
    step(); at_neg(); check("mul_stall2", 32'(bus.Stall), 1);
    step(); at_neg(); check("mul_use_ack", 32'(bus.IssueAck), 1);
    step(); instr(3, 2, -1, -1, 0);
    step(); instr(4, 0, -1, -1, 0); bus.Rs = 5'd3; bus.Rt = 5'd3;
    at_neg(); check("mul_unused_ack", 32'(bus.IssueAck), 1);
    step(); instr(0, 2, -1, -1, 0);
    step(); instr(4, 0, 0, 0, 0); at_neg(); check("mul_r0_ack", 32'(bus.IssueAck), 1);

    // WAW: mul $5 then lw $5, consumer at t+3
    step(); idle(); pulse_reset();
    step(); instr(5, 2, -1, -1, 0);
    step(); instr(5, 1, -1, -1, 0); at_neg(); check("waw_lw_ack", 32'(bus.IssueAck), 1);
    step(); instr(6, 0, 5, -1, 0);  at_neg(); check("waw_stall", 32'(bus.Stall), 1);
    step(); at_neg(); check("waw_use_ack", 32'(bus.IssueAck), 1);

    // branch shadow: unresolved, resolved early, flushed
    step(); idle(); pulse_reset();
    step(); instr(-1, 0, 1, 2, 1); at_neg(); check("br_ack", 32'(bus.IssueAck), 1);
    step(); instr(7, 0, -1, -1, 0); at_neg(); check("br_shadow1", 32'(bus.Stall), 1);
    step(); at_neg(); check("br_shadow2", 32'(bus.Stall), 1);
    step(); at_neg(); check("br_after_ack", 32'(bus.IssueAck), 1);
    step(); idle();
    step(); instr(-1, 0, -1, -1, 1);
    step(); instr(7, 0, -1, -1, 0); bus.BranchResolve = 1;
    at_neg(); check("br_res_stall", 32'(bus.Stall), 1);
    step(); bus.BranchResolve = 0; at_neg(); check("br_res_ack", 32'(bus.IssueAck), 1);
    step(); idle(); pulse_reset();
    step(); instr(-1, 0, -1, -1, 1);
    step(); instr(7, 0, -1, -1, 0); bus.Flush = 1;
    at_neg(); check("fl_stall", 32'(bus.Stall), 1); check("fl_no_ack", 32'(bus.IssueAck), 0);
    step(); bus.Flush = 0; at_neg(); check("fl_ack", 32'(bus.IssueAck), 1);
    check("fl_count", 32'(bus.StallCount), 0);

    // reset in the middle of a load-use stall
    step(); idle(); pulse_reset();
    step(); instr(8, 1, -1, -1, 0);
    step(); instr(9, 0, 8, 8, 0); at_neg(); check("rst_pre_stall", 32'(bus.Stall), 1);
    @(posedge clk); #3 rst = 1;
    @(posedge clk); #3 rst = 0;
    at_neg(); check("rst_use_ack", 32'(bus.IssueAck), 1);
    check("rst_count", 32'(bus.StallCount), 0);

    // ten stalled cycles: 3-bit counter pins at 7, 16-bit reaches 10
    step(); idle(); pulse_reset();
    repeat (5) begin
      step(); instr(3, 2, -1, -1, 0);
      step(); instr(4, 0, 3, -1, 0);
      step(); step();
    end
    step(); idle(); at_neg();
    check("sat_count", 32'(bus_s.StallCount), 7);
    check("full_count", 32'(bus.StallCount), 10);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      step();
      idle();
      bus.IssueValid    = ($urandom_range(0, 9) < 8);
      bus.Rs            = 5'($urandom_range(0, 7));
      bus.Rt            = 5'($urandom_range(0, 7));
      bus.RsUsed        = 1'($urandom_range(0, 1));
      bus.RtUsed        = 1'($urandom_range(0, 1));
      bus.Dst           = 5'($urandom_range(0, 7));
      bus.DstWe         = 1'($urandom_range(0, 1));
      bus.LatClass      = 2'($urandom_range(0, 3));
      bus.IsBranch      = ($urandom_range(0, 7) == 0);
      bus.BranchResolve = ($urandom_range(0, 7) == 0);
      bus.Flush         = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 199) == 0) begin
        #2 rst = 1;
        @(posedge clk); #3 rst = 0;
      end
    end
    step(); idle(); at_neg();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
